// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg
//   Shared constants and types for the interrupt controller.
//   - PC_NEXTX_* : next-address select encodings driven to the program counter.
//   - ic_state_t : return-sequencing FSM state.
package interrupt_controller_pkg;

  localparam int PC_NEXTX_W = 3;

  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_NEXT  = 3'd0;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTV0 = 3'd4;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTV1 = 3'd5;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTR0 = 3'd6;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTR1 = 3'd7;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_RET_ARMED = 1'b1
  } ic_state_t;

endpackage

// File: rtl/interrupt_controller_sync.sv
// int_sync
//   Brings one asynchronous request line into the CLK domain and reports
//   a one-cycle pulse when the synchronised level rises.
//   Ports:
//     CLK   in  system clock, rising edge
//     RESET in  asynchronous active-low reset
//     REQ   in  raw asynchronous request level
//     RISE  out one-cycle pulse on a synchronised rising edge
module int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic REQ,
  output logic RISE
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], REQ};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Combinational so PENDING sets exactly SYNC_STAGES edges after sampling.
  assign RISE = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Latches two external interrupt requests, prioritises them (INT0 over
//   INT1) and steers the program counter's next-address select on FETCH:
//   vector entry with return-address capture, or return on RETI.
//   Ports:
//     CLK, RESET             clock, asynchronous active-low reset
//     FETCH, DECODE          instruction phase strobes
//     INT0_REQ, INT1_REQ     raw asynchronous requests (rising edge)
//     INTE_SET/INTE_CLR/RETI decoder controls, sampled with DECODE
//     PC_NEXTX_IN            decoder's next-address select
//     PC_NEXTX               next-address select to the program counter
//     PC_LD_INT0X/1X         return-address capture strobes (FETCH only)
//     INT0_ACK/INT1_ACK      one-cycle pulse the cycle after a take
//     INT_EN, PENDING, IN_SERVICE  status (bit0 = INT0)
//   FSM state is held in fsm_state for observation.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FETCH,
  input  logic                  DECODE,
  input  logic                  INT0_REQ,
  input  logic                  INT1_REQ,
  input  logic                  INTE_SET,
  input  logic                  INTE_CLR,
  input  logic                  RETI,
  input  logic [PC_NEXTX_W-1:0] PC_NEXTX_IN,
  output logic [PC_NEXTX_W-1:0] PC_NEXTX,
  output logic                  PC_LD_INT0X,
  output logic                  PC_LD_INT1X,
  output logic                  INT0_ACK,
  output logic                  INT1_ACK,
  output logic                  INT_EN,
  output logic [1:0]            PENDING,
  output logic [1:0]            IN_SERVICE
);

  ic_state_t  fsm_state, state_d;
  logic [1:0] rise;
  logic [1:0] pend_clr, svc_set, svc_clr, ack_d;
  logic       take0, take1;

  int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
    .CLK(CLK), .RESET(RESET), .REQ(INT0_REQ), .RISE(rise[0])
  );
  int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .CLK(CLK), .RESET(RESET), .REQ(INT1_REQ), .RISE(rise[1])
  );

  // INT1 is held off while INT0 is in service, so nesting never exceeds 2.
  assign take0 = INT_EN & PENDING[0] & ~IN_SERVICE[0];
  assign take1 = INT_EN & PENDING[1] & ~IN_SERVICE[0] & ~IN_SERVICE[1] & ~take0;

  always_comb begin
    state_d     = fsm_state;
    PC_NEXTX    = PC_NEXTX_IN;
    PC_LD_INT0X = 1'b0;
    PC_LD_INT1X = 1'b0;
    pend_clr    = 2'b00;
    svc_set     = 2'b00;
    svc_clr     = 2'b00;
    ack_d       = 2'b00;
    unique case (fsm_state)
      ST_RET_ARMED: begin
        // Return to the most recently entered level; a spurious RETI
        // simply passes the decoder's select through.
        if (IN_SERVICE[0])      PC_NEXTX = PC_NEXTX_INTR0;
        else if (IN_SERVICE[1]) PC_NEXTX = PC_NEXTX_INTR1;
        if (FETCH) begin
          state_d = ST_RUN;
          if (IN_SERVICE[0])      svc_clr[0] = 1'b1;
          else if (IN_SERVICE[1]) svc_clr[1] = 1'b1;
        end
      end
      default: begin
        if (take0) begin
          PC_NEXTX = PC_NEXTX_INTV0;
          if (FETCH) begin
            PC_LD_INT0X = 1'b1;
            svc_set[0]  = 1'b1;
            pend_clr[0] = 1'b1;
            ack_d[0]    = 1'b1;
          end
        end else if (take1) begin
          PC_NEXTX = PC_NEXTX_INTV1;
          if (FETCH) begin
            PC_LD_INT1X = 1'b1;
            svc_set[1]  = 1'b1;
            pend_clr[1] = 1'b1;
            ack_d[1]    = 1'b1;
          end
        end
        if (RETI && DECODE) state_d = ST_RET_ARMED;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fsm_state  <= ST_RUN;
      INT_EN     <= 1'b0;
      PENDING    <= 2'b00;
      IN_SERVICE <= 2'b00;
      INT0_ACK   <= 1'b0;
      INT1_ACK   <= 1'b0;
    end else begin
      fsm_state  <= state_d;
      // A new edge in the same cycle as the clear keeps the flag set.
      PENDING    <= (PENDING & ~pend_clr) | rise;
      IN_SERVICE <= (IN_SERVICE | svc_set) & ~svc_clr;
      INT0_ACK   <= ack_d[0];
      INT1_ACK   <= ack_d[1];
      if (DECODE) begin
        if (INTE_CLR)      INT_EN <= 1'b0;
        else if (INTE_SET) INT_EN <= 1'b1;
      end
    end
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Upstream of the program counter; owns PC_NEXTX selection and the PC_LD_INT0X / PC_LD_INT1X return-address captures.
- Synchronises two external interrupt request lines and latches them as pending.
- Prioritises pending requests (INT0 over INT1) against the global enable and in-service state.
- On a FETCH cycle, either redirects the PC to a vector (saving the return address) or restores it on return-from-interrupt; otherwise passes the decoder's PC_NEXTX through.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each request synchroniser (minimum 2).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- FETCH  in  1  fetch-phase strobe, one cycle per instruction.
- DECODE  in  1  decode-phase strobe.
- INT0_REQ  in  1  raw, asynchronous INT0 request; rising edge significant.
- INT1_REQ  in  1  raw, asynchronous INT1 request; rising edge significant.
- INTE_SET  in  1  decoder: enable interrupts; sampled when DECODE=1.
- INTE_CLR  in  1  decoder: disable interrupts; sampled when DECODE=1.
- RETI  in  1  decoder: return-from-interrupt; sampled when DECODE=1.
- PC_NEXTX_IN  in  3  decoder's PC_NEXTX request.
- PC_NEXTX  out  3  next-address select to program counter.
- PC_LD_INT0X  out  1  capture return address into INTR0.
- PC_LD_INT1X  out  1  capture return address into INTR1.
- INT0_ACK  out  1  one-cycle pulse when INT0 is taken.
- INT1_ACK  out  1  one-cycle pulse when INT1 is taken.
- INT_EN  out  1  global interrupt enable.
- PENDING  out  2  pending flags, bit0=INT0.
- IN_SERVICE  out  2  in-service flags, bit0=INT0.

Behaviour:
- Reset (RESET=0, asynchronous): all registers are cleared.
  - INT_EN=0, PENDING=00, IN_SERVICE=00, synchronisers=0, FSM=RUN.
  - Both ACK outputs=0.
  - Combinational outputs then follow the RUN rules.
- Synchronisers: SYNC_STAGES flip-flops plus an edge flop.
  - PENDING[n] sets on the cycle the synchronised level rises.
  - Latency: a request sampled at edge k sets PENDING at edge k+SYNC_STAGES.
  - A held-high level does not re-trigger. A pulse shorter than one CLK period may be lost.
- Enable:
  - INTE_SET & DECODE sets INT_EN; INTE_CLR & DECODE clears it.
  - If both are asserted, clear wins.
  - INT_EN stays set while interrupts are serviced.
- Eligibility (combinational):
  - take0 = INT_EN & PENDING[0] & ~IN_SERVICE[0].
  - take1 = INT_EN & PENDING[1] & ~IN_SERVICE[0] & ~IN_SERVICE[1] & ~take0.
  - INT0 may preempt INT1; INT1 never preempts INT0. Nesting depth is at most 2.
- FSM states: RUN, RET_ARMED.
  - RUN with RETI & DECODE -> RET_ARMED.
  - RET_ARMED with FETCH -> RUN.
- Output selection (combinational; the captures and ACKs are qualified by FETCH):
  - RET_ARMED:
    - PC_NEXTX = INTR0 if IN_SERVICE[0], else INTR1 if IN_SERVICE[1], else PC_NEXTX_IN (a spurious RETI is a no-op return).
    - On the FETCH edge, clear the highest set IN_SERVICE bit.
    - No interrupt is taken on this FETCH; a pending request is taken on the next FETCH.
  - RUN & take0:
    - PC_NEXTX = INTV0 and PC_LD_INT0X = 1.
    - On the FETCH edge: IN_SERVICE[0] <= 1, PENDING[0] <= 0, INT0_ACK pulses the following cycle.
  - RUN & take1: as take0, using INTV1, PC_LD_INT1X, IN_SERVICE[1], PENDING[1] and INT1_ACK.
  - Otherwise: PC_NEXTX = PC_NEXTX_IN and both LD outputs = 0.
  - Outside FETCH, PC_NEXTX still follows these rules, but no state changes.
- Simultaneous events:
  - A new edge on the same cycle a pending flag clears re-sets it (set wins).
  - Both requests arriving together: INT0 is taken first, INT1 stays pending.
  - Reset mid-FETCH aborts everything; no ACK is emitted.

Decomposition:
- The PC_NEXTX_* encodings (NEXT, INTV0, INTV1, INTR0, INTR1) come from the shared constants include; no literals in the block.
- One sub-module, int_sync, is instantiated twice: synchroniser plus rising-edge detect, outputs a one-cycle rise pulse.

Test Plan:
- Reset, then INTE_SET and raise INT0_REQ -> PENDING=01 after 2 edges.
  - Next FETCH: PC_NEXTX=INTV0, PC_LD_INT0X=1.
  - Following cycle: INT0_ACK=1, IN_SERVICE=01, PENDING=00.
- INT0_REQ and INT1_REQ rise on the same edge with INT_EN=1.
  - First FETCH selects INTV0.
  - RETI then FETCH: PC_NEXTX=INTR0, IN_SERVICE=00.
  - Next FETCH: PC_NEXTX=INTV1.
- IN_SERVICE=10 and INT0 arrives -> INT0 preempts (IN_SERVICE=11).
  - Two RETI sequences select INTR0, then INTR1; IN_SERVICE ends at 00.
- INT_EN=0 with INT1 raised -> PENDING=10 held and PC_NEXTX=PC_NEXTX_IN over 5 FETCHes.
  - INTE_SET -> taken on the next FETCH.
- INTE_SET and INTE_CLR in the same DECODE -> INT_EN=0. RETI with IN_SERVICE=00 -> PC_NEXTX=PC_NEXTX_IN, no state change.
- Assert RESET low mid-FETCH while take0 is pending -> all outputs return to reset values immediately and no ACK is emitted.
